pc_disparo: RTL and testbench

Opponent (PC) shot engine: on each PC turn it picks an unshot cell of the player's 5x5 board, fires at it, and returns the updated board with hit/miss status. It is the counterpart of the player shot logic and targets the player board instead of the PC board. It sits between the game-control FSM, which issues `go` and consumes `done`, and the player board register, which latches `updated_player_board` on `done`. Targeting is pseudo-random (LFSR), with a neighbour-hunt mode after a hit and a linear-scan fallback that guarantees termination.

---
 rtl/pc_disparo_pkg.sv | 28 ++
 rtl/pc_disparo_if.sv | 17 +
 rtl/pc_disparo_lfsr5.sv | 13 +
 rtl/pc_disparo.sv | 173 +++++++++++++++++
 tb/tb_pc_disparo.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_disparo_pkg.sv
// Shared battleship definitions: cell codes, game state, board type and PC engine states.
// Used by both the player and PC shot engines.
package batalla_pkg;

  localparam int GRID_DEF = 5;

  localparam logic [2:0] WATER = 3'b001;
  localparam logic [2:0] SHIP  = 3'b010;
  localparam logic [2:0] HIT   = 3'b111;
  localparam logic [2:0] NHIT  = 3'b100;
  localparam logic [2:0] PLAY  = 3'b010;

  typedef logic [GRID_DEF-1:0][GRID_DEF-1:0][2:0] board_t;

  typedef enum logic [2:0] {IDLE, HUNT, PICK, SCAN, FIRE, DONE} pc_state_t;

  function automatic logic is_shot(input logic [2:0] c);
    return (c == HIT) || (c == NHIT);
  endfunction

  // Coordinates are 4 bits so that x-1 at the edge wraps to 15 and fails the bound test.
  function automatic logic usable(input board_t b, input logic [3:0] x, input logic [3:0] y,
                                  input logic [3:0] lim);
    if (x >= lim || y >= lim) return 1'b0;
    return !is_shot(b[x[2:0]][y[2:0]]);
  endfunction

endpackage

// File: rtl/pc_disparo_if.sv
// Request/status bundle between game control (master) and the PC shot engine (slave).
interface pc_disparo_if;
  logic       go;
  logic       turno;
  logic [2:0] estado;
  logic       busy;
  logic       done;
  logic [2:0] shot_x;
  logic [2:0] shot_y;
  logic       hit;
  logic       no_target;

  modport master (output go, turno, estado,
                  input  busy, done, shot_x, shot_y, hit, no_target);
  modport slave  (input  go, turno, estado,
                  output busy, done, shot_x, shot_y, hit, no_target);
endinterface

// File: rtl/pc_disparo_lfsr5.sv
// Free-running 5-bit LFSR used as the PC's target candidate source.
module lfsr5 (
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= 5'b00001;
    else       q <= {q[3:0], q[4] ^ q[2]};
  end

endmodule

// File: rtl/pc_disparo.sv
// PC shot engine: picks an unshot player cell (hunt, random pick, linear scan),
// fires at it and returns the updated player board.
module pc_disparo
  import batalla_pkg::*;
#(
  parameter int GRID    = GRID_DEF,
  parameter int HUNT_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  pc_disparo_if.slave       bus,
  input  board_t            player_board,
  output board_t            updated_player_board
);

  localparam logic [3:0] LIM = 4'(GRID);

  pc_state_t  state, state_n;
  logic [4:0] lfsr;
  logic [4:0] cnt;
  logic [2:0] tx, ty;
  logic [2:0] ax, ay;
  logic       av;
  logic [2:0] sx, sy;
  logic       hit_r, nt_r;
  logic       play;
  logic       take, clr_anchor, set_nt;
  logic       cand_ok;
  logic [2:0] cx, cy;
  logic [3:0] hx, hy;
  logic       tgt_ship;
  board_t     fired;

  lfsr5 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign play = (bus.estado == PLAY);

  // Candidate for the current evaluation cycle
  always_comb begin
    hx      = {1'b0, ax};
    hy      = {1'b0, ay};
    cx      = '0;
    cy      = '0;
    cand_ok = 1'b0;
    case (cnt[1:0])
      2'd0:    hx = {1'b0, ax} - 4'd1;
      2'd1:    hx = {1'b0, ax} + 4'd1;
      2'd2:    hy = {1'b0, ay} - 4'd1;
      default: hy = {1'b0, ay} + 4'd1;
    endcase
    case (state)
      HUNT: begin
        cx      = hx[2:0];
        cy      = hy[2:0];
        cand_ok = usable(player_board, hx, hy, LIM);
      end
      PICK: begin
        cx      = 3'(lfsr / 5'd5);
        cy      = 3'(lfsr % 5'd5);
        cand_ok = (lfsr < 5'd25) && usable(player_board, {1'b0, cx}, {1'b0, cy}, LIM);
      end
      SCAN: begin
        cx      = 3'(cnt / 5'd5);
        cy      = 3'(cnt % 5'd5);
        cand_ok = usable(player_board, {1'b0, cx}, {1'b0, cy}, LIM);
      end
      default: ;
    endcase
  end

  always_comb begin
    tgt_ship          = (player_board[tx][ty] == SHIP);
    fired             = player_board;
    fired[tx][ty]     = tgt_ship ? HIT : NHIT;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    take       = 1'b0;
    clr_anchor = 1'b0;
    set_nt     = 1'b0;
    if (state != IDLE && !play) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:
          if (bus.go && !bus.turno && play)
            state_n = (av && HUNT_EN != 0) ? HUNT : PICK;
        HUNT:
          if (cand_ok) begin
            take    = 1'b1;
            state_n = FIRE;
          end else if (cnt == 5'd3) begin
            clr_anchor = 1'b1;
            state_n    = PICK;
          end
        PICK:
          if (cand_ok) begin
            take    = 1'b1;
            state_n = FIRE;
          end else if (cnt == 5'd30) begin
            state_n = SCAN;
          end
        SCAN:
          if (cand_ok) begin
            take    = 1'b1;
            state_n = FIRE;
          end else if (cnt == 5'd24) begin
            set_nt  = 1'b1;
            state_n = DONE;
          end
        FIRE:    state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // cnt restarts on every state change, so it is the per-state attempt index
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt                  <= '0;
      tx                   <= '0;
      ty                   <= '0;
      ax                   <= '0;
      ay                   <= '0;
      av                   <= 1'b0;
      sx                   <= '0;
      sy                   <= '0;
      hit_r                <= 1'b0;
      nt_r                 <= 1'b0;
      updated_player_board <= '0;
    end else begin
      cnt <= (state_n == state) ? cnt + 5'd1 : '0;
      if (take) begin
        tx <= cx;
        ty <= cy;
      end
      if (clr_anchor) av <= 1'b0;
      if (set_nt) nt_r <= 1'b1;
      if (state == IDLE) updated_player_board <= player_board;
      if (state == FIRE && state_n == DONE) begin
        updated_player_board <= fired;
        sx    <= tx;
        sy    <= ty;
        hit_r <= tgt_ship;
        nt_r  <= 1'b0;
        if (tgt_ship) begin
          ax <= tx;
          ay <= ty;
          av <= 1'b1;
        end
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.shot_x    = sx;
  assign bus.shot_y    = sy;
  assign bus.hit       = hit_r;
  assign bus.no_target = nt_r;

endmodule

// File: tb/tb_pc_disparo.sv
// Self-checking bench for pc_disparo against a candidate-list reference model.
module tb_pc_disparo;
  import batalla_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  board_t player_board;
  board_t updated_player_board;

  pc_disparo_if bus();

  pc_disparo #(.GRID(5), .HUNT_EN(1)) dut (
    .clk                  (clk),
    .reset                (reset),
    .bus                  (bus),
    .player_board         (player_board),
    .updated_player_board (updated_player_board)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [4:0] m_lfsr;
  logic       m_av;
  int         m_ax, m_ay, m_sx, m_sy;
  logic       m_hit, m_nt;

  function automatic logic [4:0] lstep(input logic [4:0] l);
    return {l[3:0], l[4] ^ l[2]};
  endfunction

  always @(posedge clk) begin
    if (reset) m_lfsr <= 5'b00001;
    else       m_lfsr <= lstep(m_lfsr);
  end

  function automatic logic bshot(input logic [2:0] c);
    return (c == 3'b111) || (c == 3'b100);
  endfunction

  function automatic board_t fire_board(input board_t b, input int x, input int y);
    board_t r;
    r = b;
    r[x][y] = (b[x][y] == 3'b010) ? 3'b111 : 3'b100;
    return r;
  endfunction

  function automatic board_t rand_board(input int pshot);
    board_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        if (int'($urandom_range(0, 99)) < pshot) r[x][y] = $urandom_range(0, 1) ? 3'b111 : 3'b100;
        else                                     r[x][y] = $urandom_range(0, 1) ? 3'b010 : 3'b001;
    return r;
  endfunction

  // Ordered candidate list: neighbours, 31 LFSR draws, 25 scan cells
  function automatic void predict(input board_t b, input logic av, input int ax, input int ay,
                                  input logic [4:0] l0, output int lat, output logic found,
                                  output int px, output int py, output logic dropped);
    int dx[4] = '{-1, 1, 0, 0};
    int dy[4] = '{0, 0, -1, 1};
    int pos, nx, ny, vi;
    logic [4:0] v;
    pos = 0; v = l0; found = 1'b0; dropped = 1'b0; px = 0; py = 0;
    if (av) begin
      for (int k = 0; k < 4; k++) if (!found) begin
        pos++;
        nx = ax + dx[k];
        ny = ay + dy[k];
        if (nx >= 0 && nx < 5 && ny >= 0 && ny < 5 && !bshot(b[nx][ny])) begin
          found = 1'b1; px = nx; py = ny;
        end
        v = lstep(v);
      end
      if (!found) dropped = 1'b1;
    end
    for (int k = 0; k < 31; k++) if (!found) begin
      pos++;
      vi = int'(v);
      if (vi < 25 && !bshot(b[vi / 5][vi % 5])) begin
        found = 1'b1; px = vi / 5; py = vi % 5;
      end
      v = lstep(v);
    end
    for (int i = 0; i < 25; i++) if (!found) begin
      pos++;
      if (!bshot(b[i / 5][i % 5])) begin
        found = 1'b1; px = i / 5; py = i % 5;
      end
    end
    lat = found ? pos + 2 : pos + 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_av = 1'b0; m_ax = 0; m_ay = 0; m_sx = 0; m_sy = 0; m_hit = 1'b0; m_nt = 1'b0;
  endtask

  // Pulses go for one edge; lat is the cycle index of done (c1 = first after go), -1 if none
  task automatic fire_go(input int limit, output int lat, output logic [4:0] l1);
    @(negedge clk);
    bus.go = 1'b1;
    @(posedge clk);
    #1;
    l1 = m_lfsr;
    bus.go = 1'b0;
    lat = -1;
    for (int n = 1; n <= limit && lat < 0; n++) begin
      @(negedge clk);
      if (bus.done) lat = n;
    end
  endtask

  task automatic test_reset();
    player_board = rand_board(50);
    do_reset();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.shot_x !== 3'd0 || bus.shot_y !== 3'd0) begin errors++; $display("FAIL reset_shot: got %0d,%0d want 0,0", bus.shot_x, bus.shot_y); end
    checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", bus.hit); end
    checks++; if (bus.no_target !== 1'b0) begin errors++; $display("FAIL reset_no_target: got %b want 0", bus.no_target); end
    checks++; if (updated_player_board !== '0) begin errors++; $display("FAIL reset_board: got %h want 0", updated_player_board); end
    @(negedge clk);
    checks++; if (updated_player_board !== player_board) begin errors++; $display("FAIL idle_track: got %h want %h", updated_player_board, player_board); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_forced_hit();
    int lat, elat, px, py;
    logic found, dropped;
    logic [4:0] l1;
    board_t exp;
    do_reset();
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) player_board[x][y] = 3'b100;
    player_board[3][4] = 3'b010;
    fire_go(70, lat, l1);
    predict(player_board, m_av, m_ax, m_ay, l1, elat, found, px, py, dropped);
    exp = player_board;
    exp[3][4] = 3'b111;
    checks++; if (lat !== elat || lat < 3 || lat > 62) begin errors++; $display("FAIL forced_latency: got %0d want %0d", lat, elat); end
    checks++; if (bus.shot_x !== 3'd3 || bus.shot_y !== 3'd4) begin errors++; $display("FAIL forced_shot: got %0d,%0d want 3,4", bus.shot_x, bus.shot_y); end
    checks++; if (bus.hit !== 1'b1 || bus.no_target !== 1'b0) begin errors++; $display("FAIL forced_hit: got hit=%b nt=%b want 1,0", bus.hit, bus.no_target); end
    checks++; if (updated_player_board !== exp) begin errors++; $display("FAIL forced_board: got %h want %h", updated_player_board, exp); end
    m_av = 1'b1; m_ax = 3; m_ay = 4; m_sx = 3; m_sy = 4; m_hit = 1'b1;
    player_board = exp;
  endtask

  task automatic test_hunt();
    int lat;
    logic [4:0] l1;
    board_t exp;
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++)
      player_board[x][y] = $urandom_range(0, 1) ? 3'b111 : 3'b100;
    player_board[2][4] = 3'b001;
    fire_go(70, lat, l1);
    exp = player_board;
    exp[2][4] = 3'b100;
    checks++; if (lat !== 3) begin errors++; $display("FAIL hunt_latency: got %0d want 3", lat); end
    checks++; if (bus.shot_x !== 3'd2 || bus.shot_y !== 3'd4) begin errors++; $display("FAIL hunt_shot: got %0d,%0d want 2,4", bus.shot_x, bus.shot_y); end
    checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL hunt_hit: got %b want 0", bus.hit); end
    checks++; if (updated_player_board !== exp) begin errors++; $display("FAIL hunt_board: got %h want %h", updated_player_board, exp); end
    m_sx = 2; m_sy = 4; m_hit = 1'b0;
    player_board = exp;
  endtask

  task automatic test_exhausted();
    int lat;
    logic [4:0] l1;
    do_reset();
    player_board = rand_board(100);
    fire_go(70, lat, l1);
    checks++; if (lat !== 57) begin errors++; $display("FAIL exhausted_latency: got %0d want 57", lat); end
    checks++; if (bus.no_target !== 1'b1) begin errors++; $display("FAIL exhausted_no_target: got %b want 1", bus.no_target); end
    checks++; if (updated_player_board !== player_board) begin errors++; $display("FAIL exhausted_board: got %h want %h", updated_player_board, player_board); end
    checks++; if (bus.hit !== 1'b0 || bus.shot_x !== 3'd0 || bus.shot_y !== 3'd0) begin errors++; $display("FAIL exhausted_hold: got hit=%b shot=%0d,%0d want 0,0,0", bus.hit, bus.shot_x, bus.shot_y); end
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    do_reset();
    player_board = rand_board(100);
    @(negedge clk);
    bus.go = 1'b1;
    @(posedge clk);
    #1 bus.go = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", bus.busy); end
    bus.estado = 3'b001;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b want 0", bus.busy); end
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d activity cycles want 0", seen); end
    checks++; if (updated_player_board !== player_board || bus.no_target !== 1'b0) begin errors++; $display("FAIL abort_board: got %h nt=%b want %h nt=0", updated_player_board, bus.no_target, player_board); end
    bus.estado = 3'b010;
  endtask

  task automatic test_ignored();
    int lat, first, ndone;
    logic [4:0] l1;
    // PC not on turn
    do_reset();
    player_board = rand_board(30);
    bus.turno = 1'b1;
    fire_go(20, lat, l1);
    checks++; if (lat !== -1 || bus.busy !== 1'b0) begin errors++; $display("FAIL turno_ignored: got done_at=%0d busy=%b want -1,0", lat, bus.busy); end
    checks++; if (updated_player_board !== player_board || bus.shot_x !== 3'd0 || bus.hit !== 1'b0) begin errors++; $display("FAIL turno_no_shot: got %h want %h", updated_player_board, player_board); end
    bus.turno = 1'b0;
    // go while busy is dropped
    do_reset();
    player_board = rand_board(100);
    @(negedge clk);
    bus.go = 1'b1;
    @(posedge clk);
    #1 bus.go = 1'b0;
    first = -1; ndone = 0;
    for (int n = 1; n <= 130; n++) begin
      @(negedge clk);
      if (n == 5) bus.go = 1'b1;
      if (n == 6) bus.go = 1'b0;
      if (bus.done) begin
        ndone++;
        if (first < 0) first = n;
      end
    end
    checks++; if (first !== 57) begin errors++; $display("FAIL busy_go_latency: got %0d want 57", first); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_go_dropped: got %0d dones want 1", ndone); end
    // reset mid-operation
    do_reset();
    player_board = rand_board(100);
    player_board[1][1] = 3'b010;
    @(negedge clk);
    bus.go = 1'b1;
    @(posedge clk);
    #1 bus.go = 1'b0;
    ndone = 0;
    @(negedge clk);
    if (bus.done) ndone++;
    @(negedge clk);
    if (bus.done) ndone++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_av = 1'b0; m_sx = 0; m_sy = 0; m_hit = 1'b0; m_nt = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hit !== 1'b0 || bus.no_target !== 1'b0) begin errors++; $display("FAIL midreset_flags: got busy=%b done=%b hit=%b nt=%b want 0", bus.busy, bus.done, bus.hit, bus.no_target); end
    checks++; if (bus.shot_x !== 3'd0 || bus.shot_y !== 3'd0 || updated_player_board !== '0) begin errors++; $display("FAIL midreset_regs: got shot=%0d,%0d board=%h want 0", bus.shot_x, bus.shot_y, updated_player_board); end
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d want 0", ndone); end
  endtask

  task automatic test_random();
    int lat, elat, px, py;
    logic found, dropped;
    logic [4:0] l1;
    board_t exp;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      if (s % 8 == 0) player_board = rand_board(int'($urandom_range(0, 100)));
      fire_go(70, lat, l1);
      predict(player_board, m_av, m_ax, m_ay, l1, elat, found, px, py, dropped);
      if (dropped) m_av = 1'b0;
      if (found) begin
        m_sx = px; m_sy = py; m_nt = 1'b0;
        m_hit = (player_board[px][py] == 3'b010);
        if (m_hit) begin m_av = 1'b1; m_ax = px; m_ay = py; end
        exp = fire_board(player_board, px, py);
      end else begin
        m_nt = 1'b1;
        exp = player_board;
      end
      checks++; if (lat !== elat) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", s, lat, elat); end
      checks++; if (bus.shot_x !== 3'(m_sx) || bus.shot_y !== 3'(m_sy)) begin errors++; $display("FAIL rand%0d_shot: got %0d,%0d want %0d,%0d", s, bus.shot_x, bus.shot_y, m_sx, m_sy); end
      checks++; if (bus.hit !== m_hit || bus.no_target !== m_nt) begin errors++; $display("FAIL rand%0d_flags: got hit=%b nt=%b want %b,%b", s, bus.hit, bus.no_target, m_hit, m_nt); end
      checks++; if (updated_player_board !== exp) begin errors++; $display("FAIL rand%0d_board: got %h want %h", s, updated_player_board, exp); end
      player_board = exp;
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.go       = 1'b0;
    bus.turno    = 1'b0;
    bus.estado   = 3'b010;
    player_board = '0;
    test_reset();
    test_forced_hit();
    test_hunt();
    test_exhausted();
    test_abort();
    test_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
